// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared state encoding and bit-reversal helper for the FFT loader
package fft_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    FLUSH = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } state_t;

  localparam int unsigned BITREV_MAX = 16;

  // Reverses the low n_bits of v; bits above n_bits come back as zero.
  function automatic logic [BITREV_MAX-1:0] bitrev(input logic [BITREV_MAX-1:0] v,
                                                   input int unsigned n_bits);
    logic [BITREV_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < BITREV_MAX; i++) begin
      r[BITREV_MAX-1-i] = v[i];
    end
    return r >> (BITREV_MAX - n_bits);
  endfunction

endpackage

// File: rtl/hann_lut.sv
// rtl/hann_lut.sv - registered 32-point Q1.15 Hann window ROM, one-cycle read
module hann_lut #(
  parameter int width = 16,
  parameter int N_2   = 5
) (
  input  logic             i_clk,
  input  logic [N_2-1:0]   i_adr,
  output logic [width-1:0] o_data
);

  logic [N_2-1:0]   w_fold;
  logic [width-1:0] r_data;

  // The window is symmetric about N/2, so index N-k reads the same word as k.
  assign w_fold = i_adr[N_2-1] ? (~i_adr + 1'b1) : i_adr;

  function automatic logic [15:0] half_rom(input logic [N_2-1:0] idx);
    logic [15:0] v;
    case (int'(idx))
      0:       v = 16'd0;
      1:       v = 16'd315;
      2:       v = 16'd1247;
      3:       v = 16'd2761;
      4:       v = 16'd4799;
      5:       v = 16'd7281;
      6:       v = 16'd10114;
      7:       v = 16'd13187;
      8:       v = 16'd16384;
      9:       v = 16'd19580;
      10:      v = 16'd22653;
      11:      v = 16'd25486;
      12:      v = 16'd27968;
      13:      v = 16'd30006;
      14:      v = 16'd31520;
      15:      v = 16'd32452;
      16:      v = 16'd32767;
      default: v = 16'd0;
    endcase
    return v;
  endfunction

  // Registered ROM read
  always_ff @(posedge i_clk) begin
    r_data <= width'(half_rom(w_fold));
  end

  assign o_data = r_data;

endmodule

// File: rtl/fft_loader.sv
// rtl/fft_loader.sv - windows real samples and writes them bit-reversed into FFT RAM
module fft_loader
  import fft_pkg::*;
#(
  parameter int width = 16,
  parameter int N_2   = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [width-1:0]   i_sample,
  input  logic               i_sample_valid,
  output logic               o_sample_ready,
  output logic               o_load_we,
  output logic [N_2-1:0]     o_load_adr,
  output logic [2*width-1:0] o_load_wd,
  output logic               o_fft_start,
  input  logic               i_fft_done
);

  localparam logic [N_2-1:0] K_LAST = '1;

  state_t             r_state;
  logic [N_2-1:0]     r_k;
  logic               r_ready;
  logic               r_start;

  logic               r_s1_v;
  logic [width-1:0]   r_s1_sample;
  logic [N_2-1:0]     r_s1_k;
  logic               r_s2_v;
  logic [width-1:0]   r_s2_sample;
  logic [N_2-1:0]     r_s2_k;

  logic               r_we;
  logic [N_2-1:0]     r_adr;
  logic [2*width-1:0] r_wd;

  logic                    w_accept;
  logic [width-1:0]        w_hann;
  logic signed [2*width-1:0] w_prod;
  logic signed [width-1:0] w_win;
  logic signed [width-1:0] w_re;
  logic [BITREV_MAX-1:0]   w_rev_full;
  logic [N_2-1:0]          w_rev;
  logic                    w_unused_bits;

  assign w_accept = i_sample_valid && r_ready;

  // The LUT is addressed by the natural index one cycle after accept.
  hann_lut #(.width(width), .N_2(N_2)) u_hann_lut (
    .i_clk  (i_clk),
    .i_adr  (r_s1_k),
    .o_data (w_hann)
  );

  assign w_prod = $signed(r_s2_sample) * $signed(w_hann);
  assign w_win  = w_prod[2*width-2:width-1];
  assign w_re   = w_win >>> N_2;

  assign w_rev_full = bitrev(BITREV_MAX'(r_s2_k), N_2);
  assign w_rev      = w_rev_full[N_2-1:0];

  assign w_unused_bits = ^{w_prod[2*width-1], w_prod[width-2:0], w_rev_full[BITREV_MAX-1:N_2]};

  // Frame control: accept N samples, drain the pipe, pulse start, wait for the core
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= LOAD;
      r_k     <= '0;
      r_ready <= 1'b0;
      r_start <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          r_ready <= 1'b1;
          r_start <= 1'b0;
          if (w_accept) begin
            r_k <= r_k + 1'b1;
            if (r_k == K_LAST) begin
              r_state <= FLUSH;
              r_ready <= 1'b0;
            end
          end
        end
        FLUSH: begin
          r_ready <= 1'b0;
          // Pipe empty while a write is on the outputs means that write is the last one.
          if (r_we && !r_s1_v && !r_s2_v) begin
            r_state <= START;
            r_start <= 1'b1;
          end
        end
        START: begin
          r_start <= 1'b0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (i_fft_done) begin
            r_state <= LOAD;
            r_ready <= 1'b1;
            r_k     <= '0;
          end
        end
        default: begin
          r_state <= LOAD;
          r_ready <= 1'b0;
          r_start <= 1'b0;
        end
      endcase
    end
  end

  // Pipeline valid bits follow accepted samples through the LUT and multiply stages
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1_v <= 1'b0;
      r_s2_v <= 1'b0;
    end else begin
      r_s1_v <= w_accept;
      r_s2_v <= r_s1_v;
    end
  end

  // Sample and index ride alongside the LUT read; no reset needed on data
  always_ff @(posedge i_clk) begin
    r_s1_sample <= i_sample;
    r_s1_k      <= r_k;
    r_s2_sample <= r_s1_sample;
    r_s2_k      <= r_s1_k;
  end

  // Registered RAM write port: scaled real part, zero imaginary part
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_we  <= 1'b0;
      r_adr <= '0;
      r_wd  <= '0;
    end else begin
      r_we <= r_s2_v;
      if (r_s2_v) begin
        r_adr <= w_rev;
        r_wd  <= {w_re, {width{1'b0}}};
      end
    end
  end

  assign o_sample_ready = r_ready;
  assign o_load_we      = r_we;
  assign o_load_adr     = r_adr;
  assign o_load_wd      = r_wd;
  assign o_fft_start    = r_start;

endmodule

// File: tb/tb_fft_loader.sv
// tb/tb_fft_loader.sv - self-checking bench for fft_loader
module tb_fft_loader;

  localparam int W  = 16;
  localparam int N2 = 5;
  localparam int N  = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sample = '0;
  logic        sample_valid = 1'b0;
  logic        fft_done = 1'b0;
  logic        sample_ready;
  logic        load_we;
  logic [4:0]  load_adr;
  logic [31:0] load_wd;
  logic        fft_start;

  always #5 clk = ~clk;

  fft_loader #(.width(W), .N_2(N2)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_sample       (sample),
    .i_sample_valid (sample_valid),
    .o_sample_ready (sample_ready),
    .o_load_we      (load_we),
    .o_load_adr     (load_adr),
    .o_load_wd      (load_wd),
    .o_fft_start    (fft_start),
    .i_fft_done     (fft_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int hann_ref(input int k);
    real x;
    x = 32767.0 * 0.5 * (1.0 - $cos(2.0 * 3.14159265358979 * k / N));
    return $rtoi(x + 0.5 + 1.0e-6);
  endfunction

  function automatic int rev_ref(input int k);
    int r;
    r = 0;
    for (int i = 0; i < N2; i++) r = r * 2 + ((k >> i) & 1);
    return r;
  endfunction

  function automatic logic [31:0] wd_ref(input logic [15:0] s, input int k);
    int p;
    int re;
    p  = $signed(s) * hann_ref(k);
    re = (p >>> 15) >>> N2;
    return {re[15:0], 16'h0000};
  endfunction

  typedef struct {
    logic [4:0]  adr;
    logic [31:0] wd;
  } wr_t;

  typedef struct {
    int          frame;
    int          k;
    logic [15:0] smp;
    logic [4:0]  exp_adr;
    logic [31:0] exp_wd;
  } vec_t;

  wr_t         exp_q[$];
  int          ref_k = 0;
  bit          exp_ready = 1'b0;
  logic [4:0]  log_adr[N];
  logic [31:0] log_wd[N];
  logic [4:0]  logA_adr[N];
  logic [31:0] logA_wd[N];
  int          wr_cnt = 0;
  int          cyc = 0;
  int          first_cyc = 0;
  int          last_cyc = 0;
  bit          start_pending = 1'b0;
  int          start_seen = 0;
  wr_t         e;
  vec_t        tbl[7];

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (load_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("load_adr", {27'd0, load_adr}, {27'd0, e.adr});
          check("load_wd", load_wd, e.wd);
        end
        if (wr_cnt < N) begin
          log_adr[wr_cnt] = load_adr;
          log_wd[wr_cnt]  = load_wd;
        end
        if (wr_cnt == 0) first_cyc = cyc;
        last_cyc = cyc;
        wr_cnt++;
      end
      check("fft_start", {31'd0, fft_start}, {31'd0, start_pending});
      if (start_pending && fft_start) start_seen++;
      start_pending = load_we && (wr_cnt == N);
      if (start_pending) wr_cnt = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    sample_valid = 1'b0;
    fft_done = 1'b0;
    exp_q.delete();
    wr_cnt = 0;
    start_pending = 1'b0;
    ref_k = 0;
    exp_ready = 1'b0;
    repeat (cycles) tick();
    check("rst_ready", {31'd0, sample_ready}, 32'd0);
    check("rst_we", {31'd0, load_we}, 32'd0);
    check("rst_adr", {27'd0, load_adr}, 32'd0);
    check("rst_wd", load_wd, 32'd0);
    check("rst_start", {31'd0, fft_start}, 32'd0);
    reset = 1'b0;
    tick();
    check("ready_after_reset", {31'd0, sample_ready}, 32'd1);
    exp_ready = 1'b1;
  endtask

  task automatic send(input logic [15:0] s, input int gap_max);
    int g;
    g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    repeat (g) begin
      sample_valid = 1'b0;
      sample = 16'($urandom);
      @(negedge clk);
      check("ready_gap", {31'd0, sample_ready}, 32'd1);
      tick();
    end
    sample = s;
    sample_valid = 1'b1;
    @(negedge clk);
    check("sample_ready", {31'd0, sample_ready}, {31'd0, exp_ready});
    exp_q.push_back('{adr: 5'(rev_ref(ref_k)), wd: wd_ref(s, ref_k)});
    ref_k++;
    tick();
    sample_valid = 1'b0;
    if (ref_k == N) begin
      ref_k = 0;
      exp_ready = 1'b0;
    end
  endtask

  task automatic wait_start();
    int s0;
    int t;
    s0 = start_seen;
    t = 0;
    while (start_seen == s0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (start_seen == s0) check("fft_start_timeout", 32'd0, 32'd1);
  endtask

  task automatic hold_and_done(input int hold);
    repeat (hold) begin
      @(negedge clk);
      check("ready_in_wait", {31'd0, sample_ready}, 32'd0);
    end
    tick();
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    @(negedge clk);
    check("ready_after_done", {31'd0, sample_ready}, 32'd1);
    exp_ready = 1'b1;
    tick();
  endtask

  task automatic run_frame(input int f, input bit all_max, input int gap);
    logic [15:0] s;
    for (int k = 0; k < N; k++) begin
      s = all_max ? 16'h7FFF : 16'($urandom);
      for (int i = 0; i < 7; i++) begin
        if (tbl[i].frame == f && tbl[i].k == k) s = tbl[i].smp;
      end
      send(s, gap);
    end
    wait_start();
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].frame == f) begin
        check($sformatf("vec%0d_adr", i), {27'd0, log_adr[tbl[i].k]}, {27'd0, tbl[i].exp_adr});
        check($sformatf("vec%0d_wd", i), log_wd[tbl[i].k], tbl[i].exp_wd);
      end
    end
  endtask

  initial begin
    int starts_before;

    tbl[0] = '{frame: 0, k: 0,  smp: 16'h7FFF, exp_adr: 5'd0,  exp_wd: 32'h0000_0000};
    tbl[1] = '{frame: 0, k: 16, smp: 16'h7FFF, exp_adr: 5'd1,  exp_wd: 32'h03FF_0000};
    tbl[2] = '{frame: 0, k: 1,  smp: 16'h7FFF, exp_adr: 5'd16, exp_wd: 32'h0009_0000};
    tbl[3] = '{frame: 0, k: 31, smp: 16'h7FFF, exp_adr: 5'd31, exp_wd: 32'h0009_0000};
    tbl[4] = '{frame: 1, k: 16, smp: 16'h8000, exp_adr: 5'd1,  exp_wd: 32'hFC00_0000};
    tbl[5] = '{frame: 1, k: 8,  smp: 16'h7FFF, exp_adr: 5'd2,  exp_wd: 32'h01FF_0000};
    tbl[6] = '{frame: 3, k: 0,  smp: 16'h1234, exp_adr: 5'd0,  exp_wd: 32'h0000_0000};

    do_reset(3);

    // Frame 0: full-rate 0x7FFF
    run_frame(0, 1'b1, 0);
    check("consecutive_writes", 32'(last_cyc - first_cyc), 32'd31);
    for (int i = 0; i < N; i++) begin
      logA_adr[i] = log_adr[i];
      logA_wd[i]  = log_wd[i];
    end
    hold_and_done(20);

    // Frame 1: random data with bubbles, negative full-scale at the window peak
    run_frame(1, 1'b0, 3);
    hold_and_done(2);

    // Frame 2: same data as frame 0 with bubbles must give the same writes
    run_frame(2, 1'b1, 4);
    for (int i = 0; i < N; i++) begin
      check("gap_vs_nogap_adr", {27'd0, log_adr[i]}, {27'd0, logA_adr[i]});
      check("gap_vs_nogap_wd", log_wd[i], logA_wd[i]);
    end
    hold_and_done(3);

    // Partial frame then reset: no start pulse, next frame restarts at k=0
    starts_before = start_seen;
    for (int i = 0; i < 10; i++) send(16'($urandom), 0);
    do_reset(2);
    repeat (6) tick();
    check("no_start_after_abort", 32'(start_seen), 32'(starts_before));
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    check("done_in_load_ignored", {31'd0, sample_ready}, 32'd1);

    run_frame(3, 1'b0, 2);
    check("frame3_start_count", 32'(start_seen), 32'(starts_before + 1));
    hold_and_done(1);

    repeat (4) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_loader.md
# fft_loader

Front-end loader for the FFT core. It accepts a stream of real, signed Q1.15 samples over a valid/ready handshake and applies the Hann window from `hann_lut`. It pre-scales each product against FFT bit growth and writes the result as complex words (imaginary part 0) into the FFT RAM at bit-reversed addresses. After the last word of an N-point frame is written, it pulses `fft_start` and holds off new input until the core reports `fft_done`.

## Interface
- `width`, 16: real/imag component width; must equal `q` used to generate `rom/hann.vectors`.
- `N_2`, 5: log2 of FFT points; N = 2**N_2.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `sample`  in  width  signed Q1.15 real input sample.
- `sample_valid`  in  1  `sample` is valid this cycle.
- `sample_ready`  out  1  loader accepts `sample` this cycle.
- `load_we`  out  1  RAM write enable (one word per cycle).
- `load_adr`  out  N_2  RAM write address (bit-reversed sample index).
- `load_wd`  out  2*width  write data `{re, im}`; `im` is always 0.
- `fft_start`  out  1  one-cycle pulse; frame fully written.
- `fft_done`  in  1  FFT core finished; loader may begin the next frame.

## Operation
- Accept: a sample is accepted when `sample_valid && sample_ready`. A sample index counter k (N_2 bits) increments only on accept.
- States:
  - LOAD: `sample_ready`=1. On accept with k=N-1, go to FLUSH.
  - FLUSH: `sample_ready`=0. Wait for the final write, then go to START.
  - START: `fft_start`=1 for exactly one cycle, then go to WAIT.
  - WAIT: `sample_ready`=0. On `fft_done`=1, go to LOAD with k=0.
- `fft_done` is ignored in LOAD, FLUSH and START.
- Arithmetic per accepted sample k:
  - p = sample × hann[k], signed 2·width bits.
  - w = p[2·width−2 : width−1].
  - re = w >>> N_2 (arithmetic shift; gives headroom for N_2 stages of growth).
  - `load_wd` = {re, width'0}.
- Addressing: `load_adr` = bitrev_N_2(k). The Hann LUT is indexed by the natural k, not the reversed address.
- `load_we` is high only for cycles carrying an accepted sample; bubbles in `sample_valid` produce no writes.
- Reset at any point (including mid-frame or in WAIT):
  - k=0, state=LOAD, pipeline valid bits cleared.
  - Partial frame discarded; no `fft_start` issued.
- Reset values: `sample_ready`=0, `load_we`=0, `load_adr`=0, `load_wd`=0, `fft_start`=0. `sample_ready` rises the first cycle after `reset` is deasserted.

## Timing
- 2-cycle write latency:
  - Sample accepted at edge t.
  - Hann LUT output registered at t+1, with sample and k delayed alongside.
  - Multiply/shift result registered into `load_we`/`load_adr`/`load_wd`, visible after edge t+2.
- Full-rate: back-to-back accepts produce back-to-back writes.
- `fft_start` is high during the cycle after the last write of the frame (edge t_last+3). Exactly one pulse per complete frame.
- `sample_ready` falls in the cycle after accepting sample N−1. It rises in the cycle after `fft_done` is sampled high in WAIT.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `fft_pkg`:
  - state enum {LOAD, FLUSH, START, WAIT};
  - `bitrev` function parameterised by N_2.
- Sub-module: reuse the existing `hann_lut` (registered, 1-cycle read). Do not duplicate the ROM.
- Multiply is inline signed; no separate module.

## Test plan
(N_2=5, width=16; hann[0]=0, hann[16]=0x7FFF.)
- Reset held 3 cycles → all outputs 0. `sample_ready`=1 on the first cycle after release.
- 32 back-to-back samples of 0x7FFF:
  - write 0: `load_adr`=0, `load_wd`=0;
  - k=16 writes `load_adr`=1, `load_wd`=0x03FF_0000;
  - k=1 writes `load_adr`=16;
  - 32 consecutive writes, then `fft_start` for one cycle.
- Sample 0x8000 at k=16 → `load_wd`=0xFC00_0000 at `load_adr`=1.
- Random `sample_valid` gaps → identical address/data sequence to the gap-free run, with `load_we` low on non-accept cycles.
- After `fft_start`, hold `fft_done`=0 for 20 cycles → `sample_ready` stays 0. Pulse `fft_done` → `sample_ready`=1 next cycle, and the next frame's first write goes to `load_adr`=0.
- `reset` after 10 accepted samples → no `fft_start`. Next frame writes k=0 at `load_adr`=0 and completes normally. A `fft_done` pulse in LOAD has no effect.
